// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit stage bridging EX requests to a simple data bus
module lsu_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      mem_op,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      rd_in,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [3:0]      dbus_be,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_gnt,
  input  logic            dbus_rvalid,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            resp_valid,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            misalign
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] op_q;
  logic [XLEN-1:0] addr_q, wdata_q, res_q, shifted;
  logic [4:0] rd_q;
  logic mis_q, accept, in_ld, in_st, in_half, in_word, in_mis, in_bus;
  logic q_st, q_byte, q_half, q_word;
  assign accept = req_valid && req_ready;
  assign in_ld = mem_op inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
  assign in_st = mem_op inside {4'b1001, 4'b1010, 4'b1011};
  assign in_half = mem_op inside {4'b0010, 4'b0101, 4'b1010};
  assign in_word = mem_op inside {4'b0011, 4'b1011};
  assign in_mis = (in_half && addr[0]) || (in_word && addr[1:0] != 2'b00);
  assign in_bus = (in_ld || in_st) && !in_mis;
  assign q_st = op_q[3];
  assign q_byte = op_q inside {4'b0001, 4'b0100, 4'b1001};
  assign q_half = op_q inside {4'b0010, 4'b0101, 4'b1010};
  assign q_word = op_q inside {4'b0011, 4'b1011};
  assign shifted = dbus_rdata >> {addr_q[1:0], 3'b000};
  // State register; reset abandons any bus transaction in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Next-state: misaligned and NONE requests bypass the bus entirely
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (in_bus ? REQ : RESP) : IDLE;
      REQ:  state_n = dbus_gnt ? (q_st ? RESP : WAIT) : REQ;
      WAIT: state_n = dbus_rvalid ? RESP : WAIT;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Capture the request and build the writeback value; unknown ops collapse to NONE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      res_q <= '0;
      mis_q <= 1'b0;
    end else if (accept) begin
      op_q <= (in_ld || in_st) ? mem_op : 4'b0000;
      addr_q <= addr;
      wdata_q <= wdata;
      rd_q <= rd_in;
      res_q <= in_bus ? '0 : addr;
      mis_q <= in_mis;
    end else if (state == WAIT && dbus_rvalid) begin
      res_q <= q_word ? shifted :
               q_half ? {{16{shifted[15] & ~op_q[2]}}, shifted[15:0]} :
                        {{24{shifted[7] & ~op_q[2]}}, shifted[7:0]};
    end
  // Bus and response outputs derive only from state and captured registers
  always_comb begin
    req_ready = state == IDLE && !rst;
    dbus_req = state == REQ;
    dbus_we = dbus_req && q_st;
    dbus_addr = dbus_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dbus_be = !dbus_req ? 4'b0000 : q_word ? 4'b1111 :
              q_half ? 4'b0011 << addr_q[1:0] : 4'b0001 << addr_q[1:0];
    dbus_wdata = !dbus_req ? '0 : q_byte ? {4{wdata_q[7:0]}} :
                 q_half ? {2{wdata_q[15:0]}} : wdata_q;
    resp_valid = state == RESP;
    resp_rd = resp_valid ? rd_q : 5'd0;
    resp_data = resp_valid ? res_q : '0;
    misalign = resp_valid && mis_q;
  end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed self-checking bench for lsu_stage
module tb_lsu_stage;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, dbus_gnt = 1'b0, dbus_rvalid = 1'b0;
  logic [3:0] mem_op = '0;
  logic [31:0] addr = '0, wdata = '0, dbus_rdata = '0;
  logic [4:0] rd_in = '0;
  logic req_ready, dbus_req, dbus_we, resp_valid, misalign;
  logic [31:0] dbus_addr, dbus_wdata, resp_data;
  logic [3:0] dbus_be;
  logic [4:0] resp_rd;
  int total = 0, fails = 0;
  lsu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .addr(addr), .wdata(wdata), .rd_in(rd_in),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .resp_valid(resp_valid),
    .resp_rd(resp_rd), .resp_data(resp_data), .misalign(misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    req_valid = 1'b1; mem_op = op; addr = a; wdata = d; rd_in = r;
    step();
    req_valid = 1'b0;
  endtask
  initial begin
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_req", dbus_req, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", req_ready, 1);
    @(negedge clk);
    // NONE passes addr through in one cycle
    issue(4'b0000, 32'h1234_5678, 32'h0, 5'd5);
    chk("none_valid", resp_valid, 1);
    chk("none_data", resp_data, 32'h1234_5678);
    chk("none_rd", resp_rd, 5);
    chk("none_mis", misalign, 0);
    chk("none_dbus", dbus_req, 0);
    chk("none_ready", req_ready, 0);
    step();
    chk("none_done", resp_valid, 0);
    chk("none_data0", resp_data, 0);
    chk("none_ready1", req_ready, 1);
    // unknown op behaves as NONE
    issue(4'b0111, 32'hDEAD_0001, 32'h0, 5'd6);
    chk("unk_data", resp_data, 32'hDEAD_0001);
    chk("unk_dbus", dbus_req, 0);
    chk("unk_mis", misalign, 0);
    step();
    // SB with two cycles of stall before grant
    issue(4'b1001, 32'h0000_1003, 32'h0000_00A5, 5'd7);
    for (int i = 0; i < 3; i++) begin
      chk("sb_req", dbus_req, 1);
      chk("sb_we", dbus_we, 1);
      chk("sb_addr", dbus_addr, 32'h0000_1000);
      chk("sb_be", dbus_be, 4'b1000);
      chk("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
      chk("sb_noresp", resp_valid, 0);
      if (i < 2) step();
    end
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    chk("sb_resp", resp_valid, 1);
    chk("sb_data", resp_data, 0);
    chk("sb_rd", resp_rd, 7);
    chk("sb_req_off", dbus_req, 0);
    chk("sb_be_off", dbus_be, 0);
    chk("sb_wd_off", dbus_wdata, 0);
    step();
    // LB and LBU of the same byte
    issue(4'b0001, 32'h0000_2002, 32'h0, 5'd3);
    chk("lb_req", dbus_req, 1);
    chk("lb_we", dbus_we, 0);
    chk("lb_be", dbus_be, 4'b0100);
    chk("lb_addr", dbus_addr, 32'h0000_2000);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    chk("lb_wait_req", dbus_req, 0);
    chk("lb_wait_resp", resp_valid, 0);
    dbus_rvalid = 1'b1; dbus_rdata = 32'h0080_0000;
    step();
    dbus_rvalid = 1'b0;
    chk("lb_resp", resp_valid, 1);
    chk("lb_data", resp_data, 32'hFFFF_FF80);
    chk("lb_rd", resp_rd, 3);
    step();
    issue(4'b0100, 32'h0000_2002, 32'h0, 5'd4);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1;
    step();
    dbus_rvalid = 1'b0;
    chk("lbu_data", resp_data, 32'h0000_0080);
    chk("lbu_rd", resp_rd, 4);
    step();
    // misaligned LW, then aligned LH at the same address
    issue(4'b0011, 32'h0000_3002, 32'h0, 5'd9);
    chk("lwm_valid", resp_valid, 1);
    chk("lwm_mis", misalign, 1);
    chk("lwm_data", resp_data, 32'h0000_3002);
    chk("lwm_rd", resp_rd, 9);
    chk("lwm_dbus", dbus_req, 0);
    step();
    chk("lwm_mis_off", misalign, 0);
    issue(4'b0010, 32'h0000_3002, 32'h0, 5'd10);
    chk("lh_req", dbus_req, 1);
    chk("lh_be", dbus_be, 4'b1100);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h8001_1234;
    step();
    dbus_rvalid = 1'b0;
    chk("lh_data", resp_data, 32'hFFFF_8001);
    chk("lh_mis", misalign, 0);
    step();
    // reset while waiting for read data
    issue(4'b0011, 32'h0000_4000, 32'h0, 5'd11);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstw_ready", req_ready, 0);
    chk("rstw_req", dbus_req, 0);
    chk("rstw_resp", resp_valid, 0);
    step();
    rst = 1'b0;
    #1 chk("rstw_ready1", req_ready, 1);
    dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    step();
    dbus_rvalid = 1'b0;
    chk("rstw_noresp", resp_valid, 0);
    chk("rstw_noreq", dbus_req, 0);
    // reset during a request drops the bus asynchronously
    issue(4'b1011, 32'h0000_5000, 32'h1122_3344, 5'd12);
    chk("sw_be", dbus_be, 4'b1111);
    chk("sw_wdata", dbus_wdata, 32'h1122_3344);
    #2 rst = 1'b1;
    #1;
    chk("rstq_req", dbus_req, 0);
    chk("rstq_be", dbus_be, 0);
    chk("rstq_wdata", dbus_wdata, 0);
    @(negedge clk);
    rst = 1'b0; dbus_gnt = 1'b1;
    step();
    chk("rstq_noresp", resp_valid, 0);
    chk("rstq_noreq", dbus_req, 0);
    // back-to-back LW then SW, bus answers immediately
    dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFE_BABE;
    issue(4'b0011, 32'h0000_6000, 32'h0, 5'd13);
    req_valid = 1'b1; mem_op = 4'b1011; addr = 32'h0000_7004; wdata = 32'h5566_7788; rd_in = 5'd14;
    chk("b2b_lw_ready0", req_ready, 0);
    chk("b2b_lw_req", dbus_req, 1);
    step();
    chk("b2b_lw_ready1", req_ready, 0);
    chk("b2b_lw_wait", resp_valid, 0);
    step();
    chk("b2b_lw_resp", resp_valid, 1);
    chk("b2b_lw_data", resp_data, 32'hCAFE_BABE);
    chk("b2b_lw_rd", resp_rd, 13);
    chk("b2b_lw_ready2", req_ready, 0);
    step();
    chk("b2b_idle_ready", req_ready, 1);
    chk("b2b_idle_resp", resp_valid, 0);
    step();
    req_valid = 1'b0;
    chk("b2b_sw_ready", req_ready, 0);
    chk("b2b_sw_req", dbus_req, 1);
    chk("b2b_sw_we", dbus_we, 1);
    chk("b2b_sw_addr", dbus_addr, 32'h0000_7004);
    chk("b2b_sw_wdata", dbus_wdata, 32'h5566_7788);
    step();
    chk("b2b_sw_resp", resp_valid, 1);
    chk("b2b_sw_rd", resp_rd, 14);
    chk("b2b_sw_data", resp_data, 0);
    step();
    chk("b2b_end_ready", req_ready, 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock; the block uses one clock only.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  EX stage presents an instruction.
REQ-005 req_ready  output  1  block can accept an instruction this cycle.
REQ-006 mem_op  input  4  0000 NONE, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; other codes are treated as NONE.
REQ-007 addr  input  XLEN  ALU result: effective address, or the pass-through value for NONE.
REQ-008 wdata  input  XLEN  store data (rs2).
REQ-009 rd_in  input  5  destination register tag.
REQ-010 dbus_req / dbus_we  output  1 / 1  bus request and write strobe.
REQ-011 dbus_addr  output  XLEN  word-aligned address; addr[1:0] forced to 00.
REQ-012 dbus_be / dbus_wdata  output  4 / XLEN  byte enables and lane-replicated write data.
REQ-013 dbus_gnt / dbus_rvalid  input  1 / 1  request accepted / read data valid.
REQ-014 dbus_rdata  input  XLEN  read word.
REQ-015 resp_valid / resp_rd / resp_data  output  1 / 5 / XLEN  one-cycle writeback result.
REQ-016 misalign  output  1  asserted with resp_valid when the access is misaligned; resp_data then carries the faulting address.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Accept: req_valid && req_ready at a clock edge; addr, mem_op, wdata and rd_in SHALL be registered at that edge.
REQ-019 NONE: IDLE->RESP; resp_data = addr, misalign = 0, no bus activity; latency 1 cycle.
REQ-020 Misaligned accesses are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=00; these SHALL go IDLE->RESP with misalign=1, resp_data=addr, and no dbus_req.
REQ-021 Aligned load or store: IDLE->REQ; dbus_req=1 while in REQ, and dbus_we=1 for stores only.
REQ-022 dbus_addr, dbus_be, dbus_wdata and dbus_we SHALL be driven from registers and SHALL stay stable while dbus_req=1 and dbus_gnt=0.
REQ-023 REQ exits on dbus_gnt: stores go to RESP (resp_data=0); loads go to WAIT.
REQ-024 WAIT holds until dbus_rvalid, then goes to RESP with the extracted load data; dbus_rvalid outside WAIT SHALL be ignored.
REQ-025 RESP: resp_valid=1 for exactly one cycle, then IDLE; a new request SHALL be accepted no earlier than the cycle after RESP.
REQ-026 Byte enables: byte ops 0001<<addr[1:0]; half ops 0011<<addr[1:0]; word ops 1111.
REQ-027 Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-028 Load extraction: shift dbus_rdata right by 8*addr[1:0]; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word through.
REQ-029 resp_rd SHALL equal the captured rd_in for every response, including misaligned ones.
REQ-030 Minimum aligned-load latency (gnt in the first REQ cycle, rvalid in the first WAIT cycle): accept edge to resp_valid = 3 cycles.
REQ-031 Minimum aligned-store latency (gnt in the first REQ cycle): accept edge to resp_valid = 2 cycles.
REQ-032 Outputs outside RESP: resp_valid=0, misalign=0, resp_data=0.
REQ-033 dbus_be and dbus_wdata SHALL be 0 whenever dbus_req=0.

Reset
REQ-034 Asserting rst SHALL immediately force state IDLE and drive every output to 0, except req_ready, which SHALL be 1 only after rst deasserts.
REQ-035 Reset in REQ or WAIT SHALL abandon the transaction, drop dbus_req asynchronously, produce no response, and ignore any later gnt or rvalid belonging to it.
REQ-036 The captured registers SHALL reset to 0.

Verification
REQ-037 NONE, addr=0x1234_5678, rd=5 -> one cycle later resp_valid=1, resp_data=0x1234_5678, resp_rd=5, dbus_req never 1.
REQ-038 SB, addr=0x0000_1003, wdata=0x0000_00A5, gnt after 2 wait cycles -> dbus_addr=0x0000_1000, be=1000, wdata=0xA5A5_A5A5 held stable; resp_valid 1 cycle after gnt.
REQ-039 LB, addr=0x0000_2002, rdata=0x0080_0000 -> resp_data=0xFFFF_FF80; repeated as LBU -> resp_data=0x0000_0080.
REQ-040 LW, addr=0x0000_3002 -> misalign=1, resp_data=0x0000_3002, no dbus_req; LH at 0x0000_3002 is aligned, be=1100.
REQ-041 LW accepted, rst pulsed while in WAIT, rvalid arrives afterwards -> no resp_valid, req_ready=1 after rst falls, dbus_req=0.
REQ-042 Back-to-back LW then SW with gnt and rvalid immediate -> resp_valid pulses 3 cycles after the LW accept and 2 cycles after the SW accept; req_ready=0 throughout busy states.
